// File: rtl/r88_pkg.sv
// rtl/r88_pkg.sv - Rocket88 register-sequencer shared types, encodings and select legality.
// R88_REGCTL_VERIFY_EN adds the readback states to the state enum.
package r88_pkg;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_MOVE  = 2'd2;
  localparam logic [1:0] OP_INCPC = 2'd3;

  localparam logic [3:0] REG_A     = 4'd0;
  localparam logic [3:0] REG_B     = 4'd1;
  localparam logic [3:0] REG_C     = 4'd2;
  localparam logic [3:0] REG_DDL   = 4'd3;
  localparam logic [3:0] REG_DDH   = 4'd4;
  localparam logic [3:0] REG_EEL   = 4'd5;
  localparam logic [3:0] REG_EEH   = 4'd6;
  localparam logic [3:0] REG_PCL   = 4'd7;
  localparam logic [3:0] REG_PCH   = 4'd8;
  localparam logic [3:0] REG_SPL   = 4'd9;
  localparam logic [3:0] REG_SPH   = 4'd10;
  localparam logic [3:0] REG_FLAGS = 4'd11;

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, HOLD, WR_LO, WR_HI, INC, FIN
`ifdef R88_REGCTL_VERIFY_EN
    , RB_LO, RB_HI
`endif
  } state_t;

  function automatic logic pairBase(input logic [3:0] sel);
    return (sel == REG_DDL) || (sel == REG_EEL) || (sel == REG_PCL) || (sel == REG_SPL);
  endfunction

  // A select is usable if it names a real register and, for pair transfers, the low half of a pair.
  function automatic logic selOk(input logic [3:0] sel, input logic wide);
    return (sel <= REG_FLAGS) && (!wide || pairBase(sel));
  endfunction

endpackage

// File: rtl/r88_regctl.sv
// rtl/r88_regctl.sv - Rocket88 register-block sequencer: expands READ/WRITE/MOVE/INCPC into strobes.
// R88_REGCTL_VERIFY_EN adds post-write readback and the sticky vfyFail output.
module r88_regctl
  import r88_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        sysClock,
  input  logic        sysReset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [1:0]  cmdOp,
  input  logic [3:0]  cmdSrc,
  input  logic [3:0]  cmdDst,
  input  logic        cmdWide,
  input  logic [15:0] cmdData,
  output logic [15:0] rdData,
  output logic        done,
  output logic        cmdErr,
  output logic [3:0]  regSel,
  output logic        regRead,
  output logic        regWrite,
  output logic        incPC,
  inout  wire  [7:0]  intD
`ifdef R88_REGCTL_VERIFY_EN
  ,
  output logic        vfyFail
`endif
);

  localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  state_t        state;
  logic [1:0]    opQ;
  logic [3:0]    srcQ;
  logic [3:0]    dstQ;
  logic          wideQ;
  logic [15:0]   holdReg;
  logic [CW-1:0] waitCnt;
  logic          busEn;
  logic [7:0]    busOut;
  logic          cmdOk;

  assign intD = busEn ? busOut : 8'hzz;

  always_comb begin
    cmdOk = 1'b1;
    case (cmdOp)
      OP_READ:  cmdOk = selOk(cmdSrc, cmdWide);
      OP_WRITE: cmdOk = selOk(cmdDst, cmdWide) && (cmdDst != REG_FLAGS);
      OP_MOVE:  cmdOk = selOk(cmdSrc, cmdWide) && selOk(cmdDst, cmdWide) && (cmdDst != REG_FLAGS);
      default:  cmdOk = 1'b1;
    endcase
  end

`ifdef R88_REGCTL_VERIFY_EN
  logic vfyBad;
  logic rbMiss;
  assign rbMiss = (state == RB_LO) ? (intD != holdReg[7:0]) : (intD != holdReg[15:8]);
`endif

  always_ff @(posedge sysClock or posedge sysReset) begin
    if (sysReset) begin
      state    <= IDLE;
      cmdReady <= 1'b1;
      regSel   <= 4'd0;
      regRead  <= 1'b0;
      regWrite <= 1'b0;
      incPC    <= 1'b0;
      busEn    <= 1'b0;
      busOut   <= 8'h00;
      rdData   <= 16'h0000;
      done     <= 1'b0;
      cmdErr   <= 1'b0;
      opQ      <= OP_READ;
      srcQ     <= 4'd0;
      dstQ     <= 4'd0;
      wideQ    <= 1'b0;
      holdReg  <= 16'h0000;
      waitCnt  <= '0;
`ifdef R88_REGCTL_VERIFY_EN
      vfyBad   <= 1'b0;
      vfyFail  <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      cmdErr <= 1'b0;
      case (state)
        IDLE: begin
          if (cmdValid) begin
            opQ      <= cmdOp;
            srcQ     <= cmdSrc;
            dstQ     <= cmdDst;
            wideQ    <= cmdWide;
            holdReg  <= cmdData;
            cmdReady <= 1'b0;
            if (!cmdOk) begin
              state  <= FIN;
              done   <= 1'b1;
              cmdErr <= 1'b1;
            end else if (cmdOp == OP_WRITE) begin
              state    <= WR_LO;
              regWrite <= 1'b1;
              regSel   <= cmdDst;
              busEn    <= 1'b1;
              busOut   <= cmdData[7:0];
            end else if (cmdOp == OP_INCPC) begin
              state <= INC;
              incPC <= 1'b1;
            end else begin
              state   <= RD_LO;
              regRead <= 1'b1;
              regSel  <= cmdSrc;
              waitCnt <= CW'(RD_LAT);
            end
          end
        end
        RD_LO, RD_HI: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - 1'b1;
          end else begin
            if (state == RD_LO) begin
              rdData       <= {8'h00, intD};
              holdReg[7:0] <= intD;
            end else begin
              rdData[15:8]  <= intD;
              holdReg[15:8] <= intD;
            end
            if (state == RD_LO && wideQ) begin
              state   <= RD_HI;
              regSel  <= srcQ + 4'd1;
              waitCnt <= CW'(RD_LAT);
            end else begin
              regRead <= 1'b0;
              if (opQ == OP_MOVE) begin
                state <= HOLD;
              end else begin
                state <= FIN;
                done  <= 1'b1;
              end
            end
          end
        end
        // Turnaround: the register block may still be driving intD from the last read.
        HOLD: begin
          state    <= WR_LO;
          regWrite <= 1'b1;
          regSel   <= dstQ;
          busEn    <= 1'b1;
          busOut   <= holdReg[7:0];
        end
        WR_LO, WR_HI: begin
          if (state == WR_LO && wideQ) begin
            state  <= WR_HI;
            regSel <= dstQ + 4'd1;
            busOut <= holdReg[15:8];
          end else begin
            regWrite <= 1'b0;
            busEn    <= 1'b0;
`ifdef R88_REGCTL_VERIFY_EN
            state   <= RB_LO;
            regRead <= 1'b1;
            regSel  <= dstQ;
            waitCnt <= CW'(RD_LAT);
            vfyBad  <= 1'b0;
`else
            state <= FIN;
            done  <= 1'b1;
`endif
          end
        end
        INC: begin
          incPC <= 1'b0;
          state <= FIN;
          done  <= 1'b1;
        end
        FIN: begin
          state    <= IDLE;
          cmdReady <= 1'b1;
        end
`ifdef R88_REGCTL_VERIFY_EN
        RB_LO, RB_HI: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - 1'b1;
          end else if (state == RB_LO && wideQ) begin
            state   <= RB_HI;
            regSel  <= dstQ + 4'd1;
            waitCnt <= CW'(RD_LAT);
            vfyBad  <= vfyBad | rbMiss;
          end else begin
            regRead <= 1'b0;
            state   <= FIN;
            done    <= 1'b1;
            cmdErr  <= vfyBad | rbMiss;
            vfyFail <= vfyFail | vfyBad | rbMiss;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r88_regctl.sv
// tb/tb_r88_regctl.sv - Bench for r88_regctl with a register-block model and per-cycle strobe model.
module tb_r88_regctl;

  localparam int RD_LAT = 1;

  logic        sysClock = 1'b0;
  logic        sysReset;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [3:0]  cmdSrc;
  logic [3:0]  cmdDst;
  logic        cmdWide;
  logic [15:0] cmdData;
  logic [15:0] rdData;
  logic        done;
  logic        cmdErr;
  logic [3:0]  regSel;
  logic        regRead;
  logic        regWrite;
  logic        incPC;
  wire  [7:0]  intD;

  logic        blkDrive = 1'b0;
  logic [7:0]  blkData = 8'h00;
  logic [7:0]  regs [0:11];
  logic        pokeEn = 1'b0;
  logic [3:0]  pokeSel = 4'd0;
  logic [7:0]  pokeVal = 8'h00;
  int          cyc = 0;

  int checks = 0;
  int failures = 0;
  int acceptCyc = 0;
  int doneCyc = 0;
  int lastIdleCyc = -1;
  bit started = 0;

  typedef struct {
    string      tag;
    logic       selChk;
    logic [3:0] sel;
    logic       rd, wr, inc, drv;
    logic [7:0] bus;
    logic       dn, err, rdChk;
    logic [15:0] rdv;
  } exp_t;

  exp_t expQ[$];

  assign intD = blkDrive ? blkData : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : gPull
    pullup (intD[g]);
  end

  r88_regctl #(.RD_LAT(RD_LAT)) dut (
    .sysClock(sysClock), .sysReset(sysReset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdSrc(cmdSrc), .cmdDst(cmdDst), .cmdWide(cmdWide), .cmdData(cmdData),
    .rdData(rdData), .done(done), .cmdErr(cmdErr),
    .regSel(regSel), .regRead(regRead), .regWrite(regWrite), .incPC(incPC),
    .intD(intD)
  );

  always #5 sysClock = ~sysClock;

  // Register block: read data is registered, so it appears on intD the cycle after regRead.
  always @(posedge sysClock) begin
    cyc      <= cyc + 1;
    blkDrive <= regRead;
    if (regRead) blkData <= (regSel <= 4'd11) ? regs[regSel] : 8'h00;
    if (regWrite && regSel <= 4'd11) regs[regSel] <= intD;
    if (incPC) {regs[8], regs[7]} <= {regs[8], regs[7]} + 16'd1;
    if (pokeEn) regs[pokeSel] <= pokeVal;
  end

  function automatic exp_t mk(input string tag, input logic selChk, input logic [3:0] sel,
                              input logic rd, input logic wr, input logic inc, input logic drv,
                              input logic [7:0] bus, input logic dn, input logic err);
    exp_t e;
    e.tag = tag; e.selChk = selChk; e.sel = sel; e.rd = rd; e.wr = wr; e.inc = inc;
    e.drv = drv; e.bus = bus; e.dn = dn; e.err = err; e.rdChk = 1'b0; e.rdv = 16'h0000;
    return e;
  endfunction

  function automatic bit okSel(input logic [3:0] s, input logic w);
    return (s <= 4'd11) && (!w || s == 4'd3 || s == 4'd5 || s == 4'd7 || s == 4'd9);
  endfunction

  // Expected strobe sequence for one command, starting the cycle after it is accepted.
  task automatic pushExp(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                         input logic wide, input logic [15:0] data);
    int n;
    bit ok;
    logic [15:0] val;
    exp_t e;
    n = wide ? 2 : 1;
    case (op)
      2'd0:    ok = okSel(src, wide);
      2'd1:    ok = okSel(dst, wide) && dst != 4'd11;
      2'd2:    ok = okSel(src, wide) && okSel(dst, wide) && dst != 4'd11;
      default: ok = 1;
    endcase
    if (!ok) begin
      expQ.push_back(mk("reject", 0, 4'd0, 0, 0, 0, 0, 8'h00, 1, 1));
      return;
    end
    if (op == 2'd3) begin
      expQ.push_back(mk("incpc", 0, 4'd0, 0, 0, 1, 0, 8'h00, 0, 0));
      expQ.push_back(mk("incpc_done", 0, 4'd0, 0, 0, 0, 0, 8'h00, 1, 0));
      return;
    end
    val = data;
    if (op == 2'd0 || op == 2'd2) begin
      val = wide ? {regs[src + 4'd1], regs[src]} : {8'h00, regs[src]};
      for (int b = 0; b < n; b++)
        for (int k = 0; k <= RD_LAT; k++)
          expQ.push_back(mk("read", 1, 4'(src + b), 1, 0, 0, 0, 8'h00, 0, 0));
    end
    if (op == 2'd2) expQ.push_back(mk("hold", 0, 4'd0, 0, 0, 0, 0, 8'h00, 0, 0));
    if (op == 2'd1 || op == 2'd2)
      for (int b = 0; b < n; b++)
        expQ.push_back(mk("write", 1, 4'(dst + b), 0, 1, 0, 1, (b == 0) ? val[7:0] : val[15:8], 0, 0));
    e = mk("done", 0, 4'd0, 0, 0, 0, 0, 8'h00, 1, 0);
    e.rdChk = (op != 2'd1);
    e.rdv   = val;
    expQ.push_back(e);
  endtask

  // Compare process: every cycle outside reset is either a modelled command cycle or idle.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge sysClock);
      if (started && !sysReset) begin
        checks++;
        if (expQ.size() > 0) begin
          e  = expQ.pop_front();
          ok = (cmdReady === 1'b0) && (regRead === e.rd) && (regWrite === e.wr) &&
               (incPC === e.inc) && (done === e.dn) && (cmdErr === e.err) &&
               (!e.selChk || regSel === e.sel);
          if (e.drv) ok = ok && (intD === e.bus);
          else if (blkDrive) ok = ok && (intD === blkData);
          else ok = ok && (intD === 8'hFF);
          if (e.rdChk) ok = ok && (rdData === e.rdv);
          if (done === 1'b1) doneCyc = cyc;
          if (!ok) begin
            failures++;
            $display("FAIL cycle_%s @%0d: got rdy=%b sel=%0d rd=%b wr=%b inc=%b dn=%b err=%b intD=%h rdData=%h; want sel=%0d(chk %b) rd=%b wr=%b inc=%b dn=%b err=%b drv=%b bus=%h rdData=%h(chk %b)",
                     e.tag, cyc, cmdReady, regSel, regRead, regWrite, incPC, done, cmdErr, intD, rdData,
                     e.sel, e.selChk, e.rd, e.wr, e.inc, e.dn, e.err, e.drv, e.bus, e.rdv, e.rdChk);
          end
        end else begin
          lastIdleCyc = cyc;
          ok = (cmdReady === 1'b1) && (regRead === 1'b0) && (regWrite === 1'b0) &&
               (incPC === 1'b0) && (done === 1'b0) && (blkDrive || intD === 8'hFF);
          if (!ok) begin
            failures++;
            $display("FAIL cycle_idle @%0d: got rdy=%b rd=%b wr=%b inc=%b dn=%b intD=%h; want rdy=1 strobes=0 bus released",
                     cyc, cmdReady, regRead, regWrite, incPC, done, intD);
          end
        end
      end
    end
  end

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 60; i++) begin
      @(negedge sysClock);
      #1;
      if (lastIdleCyc == cyc) return;
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout: got busy after 60 cycles want idle");
  endtask

  task automatic poke(input logic [3:0] sel, input logic [7:0] val);
    pokeEn = 1'b1; pokeSel = sel; pokeVal = val;
    @(posedge sysClock);
    #1;
    pokeEn = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                       input logic wide, input logic [15:0] data, input bit holdValid);
    waitIdle();
    cmdOp = op; cmdSrc = src; cmdDst = dst; cmdWide = wide; cmdData = data;
    cmdValid = 1'b1;
    @(posedge sysClock);
    #1;
    acceptCyc = cyc - 1;
    pushExp(op, src, dst, wide, data);
    if (!holdValid) cmdValid = 1'b0;
  endtask

  initial begin
    sysReset = 1'b1;
    cmdValid = 1'b0; cmdOp = 2'd0; cmdSrc = 4'd0; cmdDst = 4'd0; cmdWide = 1'b0; cmdData = 16'h0000;
    repeat (2) @(posedge sysClock);
    @(negedge sysClock);
    #1;
    lit("rst_regRead", 16'(regRead), 16'h0);
    lit("rst_regWrite", 16'(regWrite), 16'h0);
    lit("rst_incPC", 16'(incPC), 16'h0);
    lit("rst_regSel", 16'(regSel), 16'h0);
    lit("rst_rdData", rdData, 16'h0);
    lit("rst_done_err", {14'd0, done, cmdErr}, 16'h0);
    lit("rst_bus", 16'(intD), 16'h00FF);
    sysReset = 1'b0;
    @(negedge sysClock);
    #1;
    lit("rst_cmdReady", 16'(cmdReady), 16'h1);
    started = 1;

    poke(4'd0, 8'h5A);  poke(4'd1, 8'hFF);  poke(4'd2, 8'h00);  poke(4'd3, 8'h11);
    poke(4'd4, 8'h22);  poke(4'd5, 8'h00);  poke(4'd6, 8'h00);  poke(4'd7, 8'hFF);
    poke(4'd8, 8'h00);  poke(4'd9, 8'h00);  poke(4'd10, 8'h00); poke(4'd11, 8'h80);

    issue(2'd0, 4'd1, 4'd0, 1'b0, 16'h0000, 0);
    waitIdle();
    lit("read_b_rdData", rdData, 16'h00FF);
    lit("read_b_latency", 16'(doneCyc - acceptCyc), 16'd3);

    issue(2'd1, 4'd0, 4'd5, 1'b1, 16'h1234, 0);
    waitIdle();
    lit("wr_ee_lo", 16'(regs[5]), 16'h0034);
    lit("wr_ee_hi", 16'(regs[6]), 16'h0012);
    issue(2'd0, 4'd5, 4'd0, 1'b1, 16'h0000, 0);
    waitIdle();
    lit("read_ee_rdData", rdData, 16'h1234);

    issue(2'd2, 4'd0, 4'd2, 1'b0, 16'h0000, 0);
    waitIdle();
    lit("move_c", 16'(regs[2]), 16'h005A);
    lit("move_rdData", rdData, 16'h005A);

    issue(2'd0, 4'd4, 4'd0, 1'b1, 16'h0000, 0);
    waitIdle();
    lit("wide_odd_latency", 16'(doneCyc - acceptCyc), 16'd1);
    issue(2'd1, 4'd0, 4'd11, 1'b0, 16'h00AA, 0);
    waitIdle();
    lit("wr_flags_blocked", 16'(regs[11]), 16'h0080);
    issue(2'd0, 4'd12, 4'd0, 1'b0, 16'h0000, 0);
    issue(2'd0, 4'd11, 4'd0, 1'b0, 16'h0000, 0);
    waitIdle();
    lit("read_flags", rdData, 16'h0080);

    issue(2'd3, 4'd0, 4'd0, 1'b0, 16'h0000, 1);
    issue(2'd0, 4'd7, 4'd0, 1'b1, 16'h0000, 0);
    waitIdle();
    lit("pc_after_inc", rdData, 16'h0100);
    lit("pc_regs", {regs[8], regs[7]}, 16'h0100);

    issue(2'd2, 4'd3, 4'd9, 1'b1, 16'h0000, 0);
    waitIdle();
    lit("move_sp", {regs[10], regs[9]}, 16'h2211);
    lit("move_wide_rdData", rdData, 16'h2211);

    // Reset lands in the high-byte write cycle of a wide WRITE to DD.
    issue(2'd1, 4'd0, 4'd3, 1'b1, 16'hBEEF, 0);
    @(negedge sysClock);
    @(negedge sysClock);
    #1;
    sysReset = 1'b1;
    expQ.delete();
    #1;
    lit("mid_rst_regWrite", 16'(regWrite), 16'h0);
    lit("mid_rst_bus", 16'(intD), 16'h00FF);
    lit("mid_rst_regSel", 16'(regSel), 16'h0);
    @(posedge sysClock);
    @(negedge sysClock);
    sysReset = 1'b0;
    @(negedge sysClock);
    #1;
    lit("mid_rst_cmdReady", 16'(cmdReady), 16'h1);
    lit("mid_rst_ddl", 16'(regs[3]), 16'h00EF);
    lit("mid_rst_ddh", 16'(regs[4]), 16'h0022);

    issue(2'd0, 4'd3, 4'd0, 1'b1, 16'h0000, 0);
    waitIdle();
    lit("dd_after_rst", rdData, 16'h22EF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r88_regctl.md
Name: r88_regctl

Overview:
- Sequencer for the Rocket88 register block.
- Accepts one register-transfer command at a time: READ, WRITE, MOVE or INCPC.
- Expands each command into the cycle-by-cycle regSel/regRead/regWrite/incPC strobes the register block needs.
- Owns the intD bus while it drives write data; splits 16-bit pair transfers into low-then-high byte cycles.

Parameters:
- RD_LAT, 1, wait cycles between raising regRead and sampling intD (the register block registers its read data on the clock edge).

Ports:
- sysClock  in  1  system clock
- sysReset  in  1  asynchronous, active-high reset
- cmdValid  in  1  command request
- cmdReady  out  1  controller idle, command accepted when cmdValid&cmdReady
- cmdOp  in  2  0 READ, 1 WRITE, 2 MOVE, 3 INCPC
- cmdSrc  in  4  source register select (READ, MOVE)
- cmdDst  in  4  destination register select (WRITE, MOVE)
- cmdWide  in  1  16-bit pair transfer
- cmdData  in  16  write data (WRITE)
- rdData  out  16  read result
- done  out  1  one-cycle completion pulse
- cmdErr  out  1  qualifies done: command rejected
- regSel  out  4  to register block
- regRead  out  1  to register block
- regWrite  out  1  to register block
- incPC  out  1  to register block
- intD  inout  8  shared internal data bus; driven only in write states, else Z

Behaviour:
- Reset values, asserted at any time including mid-command:
  - state IDLE
  - regRead = regWrite = incPC = 0
  - regSel = 0
  - intD released (Z)
  - rdData = 0, done = 0, cmdErr = 0
  - cmdReady = 1 after reset deasserts
- cmdReady = 1 only in IDLE. A command is latched (op/src/dst/wide/data) on the accepting edge. Inputs are ignored otherwise.
- Wide legality: wide selects must be a pair base: 3 DD, 5 EE, 7 PC, 9 SP; the high byte is sel+1.
  - Wide with any other select, or any select above 11, gives no register strobes.
  - Next cycle: done=1, cmdErr=1, then IDLE.
- States: IDLE, RD_LO, RD_HI, HOLD, WR_LO, WR_HI, INC, FIN.
- READ: RD_LO holds regRead=1, regSel=src for 1+RD_LAT cycles. In the last cycle, intD is sampled into rdData[7:0] and rdData[15:8] is cleared.
  - Wide: same sequence in RD_HI with regSel=src+1, sampled into rdData[15:8].
  - Then FIN.
  - Narrow READ with RD_LAT=1: done 3 cycles after accept.
- WRITE: WR_LO drives regWrite=1, regSel=dst, intD=data[7:0] for one cycle.
  - Wide: WR_HI follows in the next cycle with regSel=dst+1, intD=data[15:8].
  - Then FIN.
- MOVE: READ sequence from src into the internal holding register, one HOLD turnaround cycle (all strobes 0, bus Z), then WRITE sequence to dst from the holding register. Wide moves the pair. rdData also gets the moved value.
- INCPC: INC asserts incPC=1 for exactly one cycle with regRead=regWrite=0, then FIN.
- FIN: done=1 for one cycle (cmdErr=0), all strobes 0, then IDLE. cmdReady rises the cycle after done.
- Bus and strobe rules:
  - regRead and regWrite are never asserted together.
  - intD is driven only in WR_LO/WR_HI.
  - incPC is only asserted in INC.
- Selecting 11 (flags) for WRITE/MOVE destination is rejected with cmdErr. Reading 11 is legal.

Optional Feature:
- Macro R88_REGCTL_VERIFY_EN.
- Defined: after every WRITE/MOVE write phase, add RB_LO (and RB_HI if wide) readback states using the same timing as READ.
  - Compare the readback against the written bytes.
  - On mismatch: done carries cmdErr=1 and the sticky output vfyFail is set; vfyFail clears only on reset.
- Undefined: no readback states, no vfyFail port, and WRITE latency is as specified above.

Decomposition:
- Package r88_pkg:
  - op encodings OP_READ/OP_WRITE/OP_MOVE/OP_INCPC
  - register select constants REG_A=0, REG_B=1, REG_C=2, REG_DDL=3, REG_DDH=4, REG_EEL=5, REG_EEH=6, REG_PCL=7, REG_PCH=8, REG_SPL=9, REG_SPH=10, REG_FLAGS=11
  - state enum
  - pair-base legality function
- No sub-module; a single FSM plus a 16-bit holding register and an RD_LAT wait counter.

Test Plan:
- Reset: assert sysReset during WR_HI of a wide WRITE -> next cycle regWrite=0, intD=Z, cmdReady=1 after release; register block high byte unwritten.
- Narrow READ src=1 with B=0xFF -> regRead high 2 cycles with regSel=1, done 3 cycles after accept, rdData=0x00FF.
- Wide WRITE dst=5 data=0x1234 -> WR_LO regSel=5 intD=0x34, next cycle regSel=6 intD=0x12, done. Follow-up wide READ src=5 -> rdData=0x1234.
- MOVE src=0 (A=0x5A) dst=2 narrow -> read A, one HOLD cycle with bus Z, write C=0x5A, rdData=0x005A.
- Wide READ src=4, and WRITE dst=11 -> no strobes, done with cmdErr=1 one cycle after accept.
- INCPC with PC=0x00FF -> exactly one incPC pulse; follow-up wide READ src=7 -> 0x0100. Back-to-back commands: cmdValid held high -> second accepted the cycle after done.
